data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl_if.sv | 23 ++
 rtl/data_mem_ctrl.sv | 156 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus of the data memory controller.
// The err signal exists only when DATA_MEM_CTRL_DMEM_ERR_EN is defined.
interface data_mem_ctrl_if #(
  parameter int DMEM_WIDTH = 16
);
  logic                  req;
  logic                  we;
  logic [1:0]            size;
  logic [DMEM_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  valid;
  logic                  busy;
`ifdef DATA_MEM_CTRL_DMEM_ERR_EN
  logic                  err;

  modport master (output req, we, size, addr, wdata, input rdata, valid, busy, err);
  modport slave  (input req, we, size, addr, wdata, output rdata, valid, busy, err);
`else
  modport master (output req, we, size, addr, wdata, input rdata, valid, busy);
  modport slave  (input req, we, size, addr, wdata, output rdata, valid, busy);
`endif
endinterface

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with byte/half/word access and fixed-latency response.
// Optional misalignment check enabled by defining DATA_MEM_CTRL_DMEM_ERR_EN.
module data_mem_ctrl #(
  parameter int DMEM_WIDTH  = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  data_mem_ctrl_if.slave   bus
);
  localparam int         DEPTH     = 1 << (DMEM_WIDTH - 2);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  logic [3:0]            wait_cnt;
  logic                  valid_r;
  logic                  busy_r;
  logic [31:0]           rdata_r;

  logic                  we_p0;
  logic [1:0]            size_p0;
  logic [DMEM_WIDTH-1:0] addr_p0;
  logic [31:0]           wdata_p0;

  logic [31:0]           mem [DEPTH];

  logic [DMEM_WIDTH-3:0] widx;
  logic [1:0]            off;
  logic [3:0]            lane_en;
  logic [31:0]           sdata;
  logic [31:0]           rd_word;
  logic                  commit;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Lanes pushed past lane 3 fall off the 4-bit result.
  function automatic logic [3:0] lanes(input logic [1:0] sz, input logic [1:0] o);
    return size_mask(sz) << o;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  o);
    logic [31:0] sh;
    sh = word >> {o, 3'b000};
    case (sz)
      2'b00:   return {24'h0, sh[7:0]};
      2'b01:   return {16'h0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

`ifdef DATA_MEM_CTRL_DMEM_ERR_EN
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] o);
    return ((sz == 2'b01) && o[0]) || (sz[1] && (o != 2'b00));
  endfunction

  logic err_r;
  logic mis_p0;

  assign mis_p0  = misaligned(size_p0, off);
  assign bus.err = err_r;
`endif

  assign widx    = addr_p0[DMEM_WIDTH-1:2];
  assign off     = addr_p0[1:0];
  assign lane_en = lanes(size_p0, off);
  assign sdata   = wdata_p0 << {off, 3'b000};
  assign rd_word = mem[widx];

`ifdef DATA_MEM_CTRL_DMEM_ERR_EN
  assign commit = (state == RESP) && we_p0 && !reset && !mis_p0;
`else
  assign commit = (state == RESP) && we_p0 && !reset;
`endif

  // Request capture: only an IDLE-state request outside reset is taken.
  always_ff @(posedge clk) begin
    if (!reset && (state == IDLE) && bus.req) begin
      we_p0    <= bus.we;
      size_p0  <= bus.size;
      addr_p0  <= bus.addr;
      wdata_p0 <= bus.wdata;
    end
  end

  // Storage: committed on the RESP edge, never cleared by reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[widx][8*b +: 8] <= sdata[8*b +: 8];
      end
    end
  end

  // Control FSM; valid/rdata are registered on the RESP edge so valid
  // appears WAIT_CYCLES+1 cycles after the accepting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      rdata_r  <= '0;
`ifdef DATA_MEM_CTRL_DMEM_ERR_EN
      err_r    <= 1'b0;
`endif
    end else begin
      valid_r <= 1'b0;
`ifdef DATA_MEM_CTRL_DMEM_ERR_EN
      err_r   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.req) begin
            busy_r   <= 1'b1;
            wait_cnt <= '0;
            state    <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            state    <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RESP: begin
          valid_r <= 1'b1;
          busy_r  <= 1'b0;
          state   <= IDLE;
`ifdef DATA_MEM_CTRL_DMEM_ERR_EN
          err_r   <= mis_p0;
          if (!we_p0) rdata_r <= mis_p0 ? 32'h0 : load_extract(rd_word, size_p0, off);
`else
          if (!we_p0) rdata_r <= load_extract(rd_word, size_p0, off);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rdata = rdata_r;
  assign bus.valid = valid_r;
  assign bus.busy  = busy_r;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed vector table, reset-abort
// sequences, continuous-request throughput and randomized traffic vs. a byte model.
module tb_data_mem_ctrl;
`ifdef DATA_MEM_CTRL_DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int RBASE = 'h100;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  data_mem_ctrl_if #(.DMEM_WIDTH(16)) b1 ();
  data_mem_ctrl_if #(.DMEM_WIDTH(16)) b3 ();

  data_mem_ctrl #(.DMEM_WIDTH(16), .WAIT_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  data_mem_ctrl #(.DMEM_WIDTH(16), .WAIT_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic [15:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  vec_t       tbl [17];
  logic [7:0] bm  [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access on dut1; returns rdata/err at the valid pulse and cycles from accept.
  task automatic access(input logic w, input logic [1:0] sz, input logic [15:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic er,
                        output int lat);
    b1.req = 1'b1; b1.we = w; b1.size = sz; b1.addr = a; b1.wdata = d;
    @(posedge clk); #1;
    b1.req = 1'b0;
    lat = 0;
    while (!b1.valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = b1.rdata;
`ifdef DATA_MEM_CTRL_DMEM_ERR_EN
    er = b1.err;
`else
    er = 1'b0;
`endif
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
  endfunction

  function automatic bit is_mis(input logic [1:0] sz, input logic [15:0] a);
    return ERR_EN && (((sz == 2'b01) && a[0]) || (nbytes(sz) == 4 && a[1:0] != 2'b00));
  endfunction

  initial begin
    logic [31:0] rd, exp, last_rd;
    logic        er;
    int          lat;
    logic        w;
    logic [1:0]  sz;
    logic [15:0] a;
    logic [31:0] d;
    logic [31:0] exp40;

    exp40 = ERR_EN ? 32'h0 : 32'hFFFFFF00;
    tbl[0]  = '{1'b1, 2'b10, 16'h0010, 32'h00000000, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b1, 2'b10, 16'h0010, 32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[2]  = '{1'b0, 2'b10, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[3]  = '{1'b1, 2'b10, 16'h0010, 32'h00000000, 32'hDEADBEEF, 1'b0};
    tbl[4]  = '{1'b1, 2'b00, 16'h0013, 32'h000000A5, 32'hDEADBEEF, 1'b0};
    tbl[5]  = '{1'b0, 2'b10, 16'h0010, 32'h0,        32'hA5000000, 1'b0};
    tbl[6]  = '{1'b0, 2'b00, 16'h0013, 32'h0,        32'h000000A5, 1'b0};
    tbl[7]  = '{1'b1, 2'b10, 16'h0020, 32'h00000000, 32'h000000A5, 1'b0};
    tbl[8]  = '{1'b1, 2'b01, 16'h0022, 32'h00001234, 32'h000000A5, 1'b0};
    tbl[9]  = '{1'b0, 2'b01, 16'h0022, 32'h0,        32'h00001234, 1'b0};
    tbl[10] = '{1'b0, 2'b10, 16'h0020, 32'h0,        32'h12340000, 1'b0};
    tbl[11] = '{1'b1, 2'b10, 16'h0040, 32'h00000000, 32'h12340000, 1'b0};
    tbl[12] = '{1'b1, 2'b10, 16'h0041, 32'hFFFFFFFF, 32'h12340000, ERR_EN};
    tbl[13] = '{1'b0, 2'b10, 16'h0040, 32'h0,        exp40,        1'b0};
    tbl[14] = '{1'b0, 2'b11, 16'h0040, 32'h0,        exp40,        1'b0};
    tbl[15] = '{1'b0, 2'b00, 16'h0041, 32'h0,        ERR_EN ? 32'h0 : 32'hFF, 1'b0};
    tbl[16] = '{1'b0, 2'b01, 16'h0043, 32'h0,        ERR_EN ? 32'h0 : 32'hFF, ERR_EN};

    b1.req = 1'b0; b1.we = 1'b0; b1.size = 2'b10; b1.addr = '0; b1.wdata = '0;
    b3.req = 1'b0; b3.we = 1'b0; b3.size = 2'b10; b3.addr = '0; b3.wdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", 32'(b1.valid), 32'h0);
    chk("reset busy",  32'(b1.busy),  32'h0);
    chk("reset rdata", b1.rdata,      32'h0);
    chk("reset busy3", 32'(b3.busy),  32'h0);
    reset = 1'b0;

    for (int k = 0; k < 17; k++) begin
      access(tbl[k].w, tbl[k].sz, tbl[k].a, tbl[k].d, rd, er, lat);
      chk($sformatf("vec%0d rdata", k), rd, tbl[k].exp);
      chk($sformatf("vec%0d latency", k), 32'(lat), 32'd2);
`ifdef DATA_MEM_CTRL_DMEM_ERR_EN
      chk($sformatf("vec%0d err", k), 32'(er), 32'(tbl[k].exp_err));
`endif
    end

    // Reset during WAIT with req held high: store aborted, no valid, no re-accept.
    b1.req = 1'b1; b1.we = 1'b1; b1.size = 2'b10; b1.addr = 16'h0040; b1.wdata = 32'h11111111;
    @(posedge clk); #1;
    chk("abort wait busy", 32'(b1.busy), 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort wait valid", 32'(b1.valid), 32'h0);
    chk("abort wait busy0", 32'(b1.busy),  32'h0);
    chk("abort wait rdata", b1.rdata,      32'h0);
    @(posedge clk); #1;
    chk("reset req valid", 32'(b1.valid), 32'h0);
    reset = 1'b0; b1.req = 1'b0;
    @(posedge clk); #1;
    chk("reset req busy", 32'(b1.busy), 32'h0);
    chk("post reset valid", 32'(b1.valid), 32'h0);
    access(1'b0, 2'b10, 16'h0040, 32'h0, rd, er, lat);
    chk("abort wait old data", rd, exp40);
    chk("abort wait latency", 32'(lat), 32'd2);

    // Reset during RESP: store still aborted.
    b1.req = 1'b1; b1.we = 1'b1; b1.size = 2'b10; b1.addr = 16'h0040; b1.wdata = 32'h22222222;
    @(posedge clk); #1;
    b1.req = 1'b0;
    @(posedge clk); #1;
    chk("abort resp busy", 32'(b1.busy), 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort resp valid", 32'(b1.valid), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort resp valid2", 32'(b1.valid), 32'h0);
    access(1'b0, 2'b10, 16'h0040, 32'h0, rd, er, lat);
    chk("abort resp old data", rd, exp40);

    // Continuous request on the WAIT_CYCLES=3 instance: period 5, busy 4 of 5.
    b3.req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk($sformatf("thru busy c%0d", i),  32'(b3.busy),  32'((i % 5) != 4));
      chk($sformatf("thru valid c%0d", i), 32'(b3.valid), 32'((i % 5) == 4));
    end
    b3.req = 1'b0;

    // Randomized traffic in a 64-byte region against a byte-level model.
    for (int i = 0; i < 16; i++) begin
      access(1'b1, 2'b10, 16'(RBASE + 4 * i), 32'h0, rd, er, lat);
      last_rd = rd;
    end
    for (int i = 0; i < 64; i++) bm[i] = 8'h00;
    for (int n = 0; n < 80; n++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = 16'(RBASE + $urandom_range(0, 63));
      d  = $urandom;
      exp = 32'h0;
      if (w) begin
        if (!is_mis(sz, a))
          for (int i = 0; i < nbytes(sz); i++)
            if (int'(a[1:0]) + i < 4) bm[int'(a) - RBASE + i] = d[8*i +: 8];
        exp = last_rd;
      end else if (!is_mis(sz, a)) begin
        for (int i = 0; i < nbytes(sz); i++)
          if (int'(a[1:0]) + i < 4) exp[8*i +: 8] = bm[int'(a) - RBASE + i];
      end
      access(w, sz, a, d, rd, er, lat);
      chk($sformatf("rnd%0d rdata we=%0b sz=%0d a=%h", n, w, sz, a), rd, exp);
      chk($sformatf("rnd%0d latency", n), 32'(lat), 32'd2);
`ifdef DATA_MEM_CTRL_DMEM_ERR_EN
      chk($sformatf("rnd%0d err", n), 32'(er), 32'(is_mis(sz, a)));
`endif
      last_rd = exp;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
